// File: rtl/cdb_writeback_rau.sv
// CDB receive side of the register allocation unit: buffers writeback broadcasts in an
// in-order FIFO, drains them to the register-file write port, and tracks pending destinations.
module cdb_writeback_rau #(
   parameter  int DEPTH     = 4,
   parameter  int NUM_WARPS = 8,
   parameter  int NUM_REGS  = 8,
   parameter  int LANES     = 8,
   localparam int WW        = $clog2(NUM_WARPS),
   localparam int RW        = $clog2(NUM_REGS),
   localparam int DW        = LANES * 32,
   localparam int SB        = NUM_WARPS * NUM_REGS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          RegWrite_CDB_RAU,
   input  logic [RW-1:0] WriteAddr_CDB_RAU,
   input  logic [WW-1:0] HWWarp_CDB_RAU,
   input  logic [DW-1:0] Data_CDB_RAU,
   input  logic [31:0]   Instr_CDB_RAU,
   input  logic [LANES-1:0] ActiveMask_CDB_RAU,
   output logic          Ready_RAU_CDB,
   input  logic          Issue_Valid_SCH_RAU,
   input  logic [WW-1:0] Issue_Warp_SCH_RAU,
   input  logic [RW-1:0] Issue_Dst_SCH_RAU,
   output logic          RFWrite_RAU_RF,
   output logic [WW-1:0] RFWarp_RAU_RF,
   output logic [RW-1:0] RFAddr_RAU_RF,
   output logic [DW-1:0] RFData_RAU_RF,
   output logic [LANES-1:0] RFMask_RAU_RF,
   output logic [31:0]   RFInstr_RAU_RF,
   input  logic          RFReady_RF_RAU,
   output logic [SB-1:0] Pending_RAU_SCH,
   output logic          Overflow_RAU
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = WW + RW;

   logic [WW-1:0]    warp_mem  [DEPTH];
   logic [RW-1:0]    addr_mem  [DEPTH];
   logic [DW-1:0]    data_mem  [DEPTH];
   logic [LANES-1:0] mask_mem  [DEPTH];
   logic [31:0]      instr_mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   logic [SB-1:0] pending_reg, pending_next;
   logic          overflow_reg;

   logic head_valid, push, pop, drop;
   logic [IW-1:0] issue_idx, retire_idx;

   // Ready looks only at the registered count, so a full FIFO refuses even while popping.
   assign Ready_RAU_CDB = !rst && (count_reg < CW'(DEPTH));
   assign head_valid    = !rst && (count_reg != '0);
   assign push          = RegWrite_CDB_RAU && Ready_RAU_CDB;
   assign drop          = RegWrite_CDB_RAU && !Ready_RAU_CDB;
   assign pop           = head_valid && RFReady_RF_RAU;

   assign RFWrite_RAU_RF = head_valid;
   assign RFWarp_RAU_RF  = head_valid ? warp_mem[rd_ptr_reg]  : '0;
   assign RFAddr_RAU_RF  = head_valid ? addr_mem[rd_ptr_reg]  : '0;
   assign RFData_RAU_RF  = head_valid ? data_mem[rd_ptr_reg]  : '0;
   assign RFMask_RAU_RF  = head_valid ? mask_mem[rd_ptr_reg]  : '0;
   assign RFInstr_RAU_RF = head_valid ? instr_mem[rd_ptr_reg] : '0;

   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + CW'(1);
      else if (pop && !push)
         count_next = count_reg - CW'(1);
   end

   // Power-of-two register count makes warp*NUM_REGS+reg a plain concatenation.
   assign issue_idx  = {Issue_Warp_SCH_RAU, Issue_Dst_SCH_RAU};
   assign retire_idx = {RFWarp_RAU_RF, RFAddr_RAU_RF};

   // Set overrides clear: a same-cycle issue is younger than the retiring writeback.
   for (genvar gi = 0; gi < SB; gi++) begin : g_sb
      logic set_bit, clr_bit;
      assign set_bit = Issue_Valid_SCH_RAU && (issue_idx == IW'(gi));
      assign clr_bit = pop && (retire_idx == IW'(gi));
      assign pending_next[gi] = set_bit || (pending_reg[gi] && !clr_bit);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         warp_mem[wr_ptr_reg]  <= HWWarp_CDB_RAU;
         addr_mem[wr_ptr_reg]  <= WriteAddr_CDB_RAU;
         data_mem[wr_ptr_reg]  <= Data_CDB_RAU;
         mask_mem[wr_ptr_reg]  <= ActiveMask_CDB_RAU;
         instr_mem[wr_ptr_reg] <= Instr_CDB_RAU;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         pending_reg  <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg   <= count_next;
         pending_reg <= pending_next;
         if (drop)
            overflow_reg <= 1'b1;
      end
   end

   assign Pending_RAU_SCH = pending_reg;
   assign Overflow_RAU    = overflow_reg;
endmodule

// File: tb/tb_cdb_writeback_rau.sv
// Directed plus random stimulus for cdb_writeback_rau, checked every cycle against a
// queue-based reference model of the writeback FIFO and scoreboard.
module tb_cdb_writeback_rau;
   logic         clk = 1'b0;
   logic         rst;
   logic         reg_write;
   logic [2:0]   write_addr;
   logic [2:0]   hw_warp;
   logic [255:0] data;
   logic [31:0]  instr;
   logic [7:0]   active_mask;
   logic         ready;
   logic         issue_valid;
   logic [2:0]   issue_warp;
   logic [2:0]   issue_dst;
   logic         rf_write;
   logic [2:0]   rf_warp;
   logic [2:0]   rf_addr;
   logic [255:0] rf_data;
   logic [7:0]   rf_mask;
   logic [31:0]  rf_instr;
   logic         rf_ready;
   logic [63:0]  pending;
   logic         overflow;

   typedef struct {
      logic [2:0]   warp;
      logic [2:0]   addr;
      logic [255:0] data;
      logic [7:0]   mask;
      logic [31:0]  instr;
   } ent_t;

   ent_t        mq[$];
   logic [63:0] m_pend;
   logic        m_ovf;
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   cdb_writeback_rau dut (
      .clk(clk), .rst(rst),
      .RegWrite_CDB_RAU(reg_write), .WriteAddr_CDB_RAU(write_addr),
      .HWWarp_CDB_RAU(hw_warp), .Data_CDB_RAU(data), .Instr_CDB_RAU(instr),
      .ActiveMask_CDB_RAU(active_mask), .Ready_RAU_CDB(ready),
      .Issue_Valid_SCH_RAU(issue_valid), .Issue_Warp_SCH_RAU(issue_warp),
      .Issue_Dst_SCH_RAU(issue_dst), .RFWrite_RAU_RF(rf_write),
      .RFWarp_RAU_RF(rf_warp), .RFAddr_RAU_RF(rf_addr), .RFData_RAU_RF(rf_data),
      .RFMask_RAU_RF(rf_mask), .RFInstr_RAU_RF(rf_instr), .RFReady_RF_RAU(rf_ready),
      .Pending_RAU_SCH(pending), .Overflow_RAU(overflow)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand_data();
      logic [255:0] d;
      for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
      return d;
   endfunction

   task automatic idle();
      reg_write = 0; write_addr = 0; hw_warp = 0; data = '0; instr = 0; active_mask = 0;
      issue_valid = 0; issue_warp = 0; issue_dst = 0;
   endtask

   task automatic drive_push(input logic [2:0] w, input logic [2:0] a, input logic [255:0] d,
                             input logic [7:0] m, input logic [31:0] i);
      reg_write = 1; hw_warp = w; write_addr = a; data = d; active_mask = m; instr = i;
   endtask

   task automatic drive_issue(input logic [2:0] w, input logic [2:0] r);
      issue_valid = 1; issue_warp = w; issue_dst = r;
   endtask

   // Compare all outputs with the model, then advance the model by the edge's rules.
   task automatic cycle();
      logic exp_ready, exp_wr, do_pop;
      ent_t h;
      ent_t e;
      @(negedge clk);
      exp_ready = !rst && (mq.size() < 4);
      exp_wr    = !rst && (mq.size() != 0);
      h = '{warp: 0, addr: 0, data: '0, mask: 0, instr: 0};
      if (exp_wr) h = mq[0];
      chk("ready", ready, exp_ready);
      chk("rf_write", rf_write, exp_wr);
      chk("rf_warp", rf_warp, h.warp);
      chk("rf_addr", rf_addr, h.addr);
      chk("rf_data", rf_data, h.data);
      chk("rf_mask", rf_mask, h.mask);
      chk("rf_instr", rf_instr, h.instr);
      chk("pending", pending, m_pend);
      chk("overflow", overflow, m_ovf);
      if (rst) begin
         mq.delete(); m_pend = '0; m_ovf = 0;
      end else begin
         do_pop = exp_wr && rf_ready;
         if (do_pop) begin
            m_pend[h.warp * 8 + h.addr] = 1'b0;
            void'(mq.pop_front());
         end
         if (issue_valid) m_pend[issue_warp * 8 + issue_dst] = 1'b1;
         if (reg_write && exp_ready) begin
            e = '{warp: hw_warp, addr: write_addr, data: data, mask: active_mask, instr: instr};
            mq.push_back(e);
         end else if (reg_write) begin
            m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_rand();
      drive_push(3'($urandom), 3'($urandom), rand_data(), 8'($urandom), $urandom);
   endtask

   initial begin
      idle(); rf_ready = 0; rst = 1;
      mq.delete(); m_pend = '0; m_ovf = 0;
      @(posedge clk); #1;
      cycle();                                   // reset held: all outputs zero
      rst = 0;

      // Basic retire
      drive_issue(2, 5); cycle(); idle();
      chk("basic_p21_set", pending[21], 1'b1);
      drive_push(2, 5, {32{8'hA5}}, 8'hFF, 32'h1234_5678); rf_ready = 1;
      cycle(); idle();
      chk("basic_rfwrite", rf_write, 1'b1);
      chk("basic_rfwarp", rf_warp, 3'd2);
      chk("basic_rfaddr", rf_addr, 3'd5);
      cycle();
      chk("basic_p21_clr", pending[21], 1'b0);
      chk("basic_empty", rf_write, 1'b0);

      // Backpressure and overflow
      rf_ready = 0;
      for (int k = 0; k < 4; k++) begin push_rand(); cycle(); end
      idle();
      chk("bp_full_ready", ready, 1'b0);
      push_rand(); cycle(); idle();
      chk("bp_overflow", overflow, 1'b1);
      rf_ready = 1;
      for (int k = 0; k < 4; k++) begin chk("bp_drain_wr", rf_write, 1'b1); cycle(); end
      chk("bp_ready_back", ready, 1'b1);
      chk("bp_ovf_sticky", overflow, 1'b1);

      // Concurrent push/pop at count 2, across pointer wrap
      rf_ready = 0;
      for (int k = 0; k < 2; k++) begin push_rand(); cycle(); end
      rf_ready = 1;
      for (int k = 0; k < 10; k++) begin
         push_rand(); cycle();
         chk("cc_ready", ready, 1'b1);
         chk("cc_wr", rf_write, 1'b1);
      end
      idle(); cycle(); cycle();

      // Set/clear collision on warp7/r3
      rf_ready = 0;
      drive_issue(7, 3); cycle(); idle();
      drive_push(7, 3, rand_data(), 8'h00, 32'hCAFE_0003); cycle(); idle();
      rf_ready = 1; drive_issue(7, 3); cycle(); idle();
      chk("collide_p59", pending[59], 1'b1);

      // Full plus pop, from a clean overflow flag
      rst = 1; cycle(); rst = 0;
      rf_ready = 0;
      for (int k = 0; k < 4; k++) begin push_rand(); cycle(); end
      rf_ready = 1; push_rand(); cycle(); idle();
      chk("fp_overflow", overflow, 1'b1);
      chk("fp_ready", ready, 1'b1);
      for (int k = 0; k < 3; k++) cycle();

      // Reset mid-operation with count 3, pending bits and overflow set
      rf_ready = 0;
      for (int k = 0; k < 5; k++) begin push_rand(); drive_issue(3'(k), 3'(k + 1)); cycle(); end
      idle(); rf_ready = 1; cycle(); rf_ready = 0;
      chk("rm_ovf_before", overflow, 1'b1);
      rst = 1; cycle();
      chk("rm_wr_in_rst", rf_write, 1'b0);
      chk("rm_pend_in_rst", pending, 64'd0);
      rst = 0; #1;
      chk("rm_ready_after", ready, 1'b1);
      chk("rm_wr_after", rf_write, 1'b0);
      cycle();

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         idle();
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 9) < 6) push_rand();
         if ($urandom_range(0, 1) == 1) drive_issue(3'($urandom), 3'($urandom));
         rf_ready = ($urandom_range(0, 9) < 6);
         cycle();
      end
      idle(); rst = 0; rf_ready = 1;
      for (int k = 0; k < 6; k++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
